// File: rtl/encoder_16to4_seq_pkg.sv
// Shared constants, FSM state type and bit-vector helpers for the sequential 16-to-4 encoder.
package encoder_pkg;

    localparam int N_LINES = 16;
    localparam int CODE_W  = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } enc_state_t;

    function automatic logic [CODE_W:0] popcount(input logic [N_LINES-1:0] vec);
        logic [CODE_W:0] cnt;
        cnt = {(CODE_W+1){1'b0}};
        for (int i = 0; i < N_LINES; i++) begin
            cnt = cnt + {{CODE_W{1'b0}}, vec[i]};
        end
        return cnt;
    endfunction

    // One-hot mask of a single line, used to retire the code just served.
    function automatic logic [N_LINES-1:0] line_mask(input logic [CODE_W-1:0] idx);
        return {{(N_LINES-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/encoder_16to4_seq_if.sv
// Handshake/bus bundle between the encoder and its producer/consumer.
interface encoder_16to4_seq_if #(
    parameter int N = encoder_pkg::N_LINES,
    parameter int M = encoder_pkg::CODE_W
) ();

    logic         En;
    logic         Load;
    logic [N-1:0] W;
    logic         Ready;
    logic [M-1:0] Y;
    logic         Valid;
    logic         Busy;
    logic [M:0]   Count;
    logic         Done;
    logic         Zero;

    modport master (
        output En, Load, W, Ready,
        input  Y, Valid, Busy, Count, Done, Zero
    );

    modport slave (
        input  En, Load, W, Ready,
        output Y, Valid, Busy, Count, Done, Zero
    );

endinterface

// File: rtl/encoder_16to4_seq_prio.sv
// Combinational priority encoder; HIGH_PRIORITY_EN selects highest-index-first,
// otherwise line 0 has the highest priority.
module prio_encode_16 #(
    parameter int N = encoder_pkg::N_LINES,
    parameter int M = encoder_pkg::CODE_W
) (
    input  logic [N-1:0] vec,
    output logic [M-1:0] idx,
    output logic         any
);

    // Scan order makes the winning line the last one written.
    always_comb begin
        idx = {M{1'b0}};
        any = |vec;
`ifdef HIGH_PRIORITY_EN
        for (int i = 0; i < N; i++) begin
            idx = vec[i] ? M'(i) : idx;
        end
`else
        for (int i = N - 1; i >= 0; i--) begin
            idx = vec[i] ? M'(i) : idx;
        end
`endif
    end

endmodule

// File: rtl/encoder_16to4_seq.sv
// Sequential 16-to-4 encoder: captures a line word, then hands out one code per handshake.
// Priority direction is set by the HIGH_PRIORITY_EN macro (via prio_encode_16).
module encoder_16to4_seq
    import encoder_pkg::*;
#(
    parameter int N = N_LINES,
    parameter int M = CODE_W
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    encoder_16to4_seq_if.slave    bus
);

    enc_state_t   state_r, state_nxt_s;
    logic [N-1:0] pending_r, pending_nxt_s;
    logic [N-1:0] enc_in_s;
    logic [M-1:0] y_r, y_nxt_s;
    logic [M-1:0] enc_idx_s;
    logic         enc_any_s;
    logic         valid_r, valid_nxt_s;
    logic [M:0]   count_r, count_nxt_s;
    logic         done_r, done_nxt_s;
    logic         zero_r, zero_nxt_s;
    logic         busy_s;
    logic         load_ok_s;
    logic         accept_s;

    assign busy_s    = (state_r == SCAN) | (|pending_r);
    assign load_ok_s = bus.En & bus.Load & ~busy_s;
    assign accept_s  = bus.En & valid_r & bus.Ready & (state_r == SCAN);

    // A single encoder serves both the first code of a Load and the next code after an accept.
    assign enc_in_s = load_ok_s ? bus.W : (pending_r & ~line_mask(y_r));

    prio_encode_16 #(.N(N), .M(M)) u_prio (
        .vec (enc_in_s),
        .idx (enc_idx_s),
        .any (enc_any_s)
    );

    // Next-state and next-output logic for the IDLE/SCAN controller.
    always_comb begin
        state_nxt_s   = state_r;
        pending_nxt_s = pending_r;
        y_nxt_s       = y_r;
        valid_nxt_s   = valid_r;
        count_nxt_s   = count_r;
        done_nxt_s    = 1'b0;
        zero_nxt_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (load_ok_s) begin
                    if (|bus.W) begin
                        pending_nxt_s = bus.W;
                        count_nxt_s   = popcount(bus.W);
                        y_nxt_s       = enc_idx_s;
                        valid_nxt_s   = 1'b1;
                        state_nxt_s   = SCAN;
                    end else begin
                        zero_nxt_s    = 1'b1;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SCAN: begin
                if (accept_s) begin
                    pending_nxt_s = enc_in_s;
                    count_nxt_s   = count_r - {{M{1'b0}}, 1'b1};
                    if (enc_any_s) begin
                        y_nxt_s     = enc_idx_s;
                    end else begin
                        valid_nxt_s = 1'b0;
                        count_nxt_s = {(M+1){1'b0}};
                        done_nxt_s  = 1'b1;
                        state_nxt_s = IDLE;
                    end
                end else begin
                    state_nxt_s = SCAN;
                end
            end
            default: begin
                state_nxt_s   = IDLE;
                pending_nxt_s = {N{1'b0}};
                valid_nxt_s   = 1'b0;
                count_nxt_s   = {(M+1){1'b0}};
            end
        endcase
    end

    // State and output registers; reset discards all pending codes without a Done pulse.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_r   <= IDLE;
            pending_r <= {N{1'b0}};
            y_r       <= {M{1'b0}};
            valid_r   <= 1'b0;
            count_r   <= {(M+1){1'b0}};
            done_r    <= 1'b0;
            zero_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            pending_r <= pending_nxt_s;
            y_r       <= y_nxt_s;
            valid_r   <= valid_nxt_s;
            count_r   <= count_nxt_s;
            done_r    <= done_nxt_s;
            zero_r    <= zero_nxt_s;
        end
    end

    // Valid drops immediately with En so no handshake can be seen while stalled.
    assign bus.Y     = y_r;
    assign bus.Valid = valid_r & bus.En;
    assign bus.Busy  = busy_s;
    assign bus.Count = count_r;
    assign bus.Done  = done_r;
    assign bus.Zero  = zero_r;

endmodule

// File: tb/tb_encoder_16to4_seq.sv
// Self-checking bench for encoder_16to4_seq: vector table, directed corner cases and
// random traffic against a queue-based model. Honours HIGH_PRIORITY_EN.
module tb_encoder_16to4_seq;
    import encoder_pkg::*;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    encoder_16to4_seq_if bus ();

    encoder_16to4_seq dut (
        .Clock  (clk),
        .Resetn (resetn),
        .bus    (bus)
    );

    int checks_total  = 0;
    int checks_passed = 0;

    // Reference model: codes still owed, in service order; q[0] is the one presented.
    int q[$];
    bit exp_done;
    bit exp_zero;

    typedef struct {
        logic        en;
        logic        load;
        logic [15:0] w;
        logic        ready;
        logic [3:0]  y;
        logic        valid;
        logic [4:0]  count;
        logic        busy;
        logic        done;
        logic        zero;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input int act, input int exp);
        checks_total++;
        if (act == exp) checks_passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic void model_load(input logic [15:0] w);
        q.delete();
`ifdef HIGH_PRIORITY_EN
        for (int i = 15; i >= 0; i--) if (w[i]) q.push_back(i);
`else
        for (int i = 0; i < 16; i++) if (w[i]) q.push_back(i);
`endif
    endfunction

    function automatic void model_edge(input logic en, input logic load,
                                       input logic [15:0] w, input logic ready);
        exp_done = 1'b0;
        exp_zero = 1'b0;
        if (q.size() > 0) begin
            if (en && ready) begin
                void'(q.pop_front());
                if (q.size() == 0) exp_done = 1'b1;
            end
        end else if (en && load) begin
            if (w == 16'h0000) exp_zero = 1'b1;
            else model_load(w);
        end
    endfunction

    task automatic check_model(input string tag);
        chk({tag, ".valid"}, int'(bus.Valid), int'(bus.En && q.size() > 0));
        chk({tag, ".busy"},  int'(bus.Busy),  int'(q.size() > 0));
        chk({tag, ".count"}, int'(bus.Count), q.size());
        chk({tag, ".done"},  int'(bus.Done),  int'(exp_done));
        chk({tag, ".zero"},  int'(bus.Zero),  int'(exp_zero));
        if (q.size() > 0) chk({tag, ".y"}, int'(bus.Y), q[0]);
    endtask

    task automatic cycle(input string tag, input logic en, input logic load,
                         input logic [15:0] w, input logic ready);
        bus.En = en; bus.Load = load; bus.W = w; bus.Ready = ready;
        @(posedge clk);
        model_edge(en, load, w, ready);
        @(negedge clk);
        check_model(tag);
    endtask

    function automatic logic [15:0] rand_w();
        case ($urandom_range(0, 3))
            0:       return 16'h0000;
            1:       return 16'h0001 << $urandom_range(0, 15);
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        int y_a, y_b;
`ifdef HIGH_PRIORITY_EN
        int seq[4] = '{15, 10, 5, 0};
`else
        int seq[4] = '{0, 5, 10, 15};
`endif
        q.delete();
        exp_done = 1'b0;
        exp_zero = 1'b0;

        // Reset held with random inputs
        resetn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.En = 1'($urandom); bus.Load = 1'($urandom);
            bus.W = 16'($urandom); bus.Ready = 1'($urandom);
            @(negedge clk);
            chk("rst.y", int'(bus.Y), 0);
            chk("rst.valid", int'(bus.Valid), 0);
            chk("rst.busy", int'(bus.Busy), 0);
            chk("rst.count", int'(bus.Count), 0);
            chk("rst.done", int'(bus.Done), 0);
            chk("rst.zero", int'(bus.Zero), 0);
        end
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) cycle("idle", 1'b1, 1'b0, 16'($urandom), 1'($urandom));

        // Vector table: W=16'h8421 streamed with Ready held high
        tbl[0] = '{1'b1, 1'b1, 16'h8421, 1'b1, 4'(seq[0]), 1'b1, 5'd4, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 16'h0000, 1'b1, 4'(seq[1]), 1'b1, 5'd3, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 16'h0000, 1'b1, 4'(seq[2]), 1'b1, 5'd2, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 16'h0000, 1'b1, 4'(seq[3]), 1'b1, 5'd1, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 16'h0000, 1'b1, 4'd0,       1'b0, 5'd0, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 16'h0000, 1'b1, 4'd0,       1'b0, 5'd0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            cycle($sformatf("tbl%0d", i), tbl[i].en, tbl[i].load, tbl[i].w, tbl[i].ready);
            chk($sformatf("tbl%0d.valid", i), int'(bus.Valid), int'(tbl[i].valid));
            chk($sformatf("tbl%0d.count", i), int'(bus.Count), int'(tbl[i].count));
            chk($sformatf("tbl%0d.busy", i),  int'(bus.Busy),  int'(tbl[i].busy));
            chk($sformatf("tbl%0d.done", i),  int'(bus.Done),  int'(tbl[i].done));
            chk($sformatf("tbl%0d.zero", i),  int'(bus.Zero),  int'(tbl[i].zero));
            if (tbl[i].valid) chk($sformatf("tbl%0d.y", i), int'(bus.Y), int'(tbl[i].y));
        end

        // Backpressure on W=16'h0006
`ifdef HIGH_PRIORITY_EN
        y_a = 2; y_b = 1;
`else
        y_a = 1; y_b = 2;
`endif
        cycle("bp.load", 1'b1, 1'b1, 16'h0006, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle("bp.hold", 1'b1, 1'b0, 16'h0000, 1'b0);
            chk("bp.hold_y", int'(bus.Y), y_a);
            chk("bp.hold_valid", int'(bus.Valid), 1);
        end
        cycle("bp.go", 1'b1, 1'b0, 16'h0000, 1'b1);
        chk("bp.second_y", int'(bus.Y), y_b);
        cycle("bp.end", 1'b1, 1'b0, 16'h0000, 1'b1);
        chk("bp.done", int'(bus.Done), 1);

        // Zero load
        cycle("zero.load", 1'b1, 1'b1, 16'h0000, 1'b1);
        chk("zero.pulse", int'(bus.Zero), 1);
        chk("zero.busy", int'(bus.Busy), 0);
        cycle("zero.after", 1'b1, 1'b0, 16'h0000, 1'b1);
        chk("zero.once", int'(bus.Zero), 0);

        // Load while busy is ignored
`ifdef HIGH_PRIORITY_EN
        y_a = 2; y_b = 0;
`else
        y_a = 0; y_b = 2;
`endif
        cycle("lb.load", 1'b1, 1'b1, 16'h0005, 1'b0);
        cycle("lb.busyload", 1'b1, 1'b1, 16'hFFFF, 1'b1);
        chk("lb.count", int'(bus.Count), 1);
        chk("lb.y", int'(bus.Y), y_b);
        cycle("lb.end", 1'b1, 1'b0, 16'h0000, 1'b1);
        chk("lb.done", int'(bus.Done), 1);

        // Load coinciding with final accept is dropped; Load on the Done cycle is taken
        cycle("fin.load", 1'b1, 1'b1, 16'h0001, 1'b1);
        cycle("fin.clash", 1'b1, 1'b1, 16'hFFFF, 1'b1);
        chk("fin.clash_busy", int'(bus.Busy), 0);
        chk("fin.clash_done", int'(bus.Done), 1);
        cycle("fin.reload", 1'b1, 1'b1, 16'h0002, 1'b1);
        chk("fin.reload_y", int'(bus.Y), 1);
        chk("fin.reload_valid", int'(bus.Valid), 1);
        cycle("fin.drain", 1'b1, 1'b0, 16'h0000, 1'b1);

        // En low freezes the sequence
`ifdef HIGH_PRIORITY_EN
        y_a = 1; y_b = 0;
`else
        y_a = 0; y_b = 1;
`endif
        cycle("en.load", 1'b1, 1'b1, 16'h0003, 1'b0);
        chk("en.first_y", int'(bus.Y), y_a);
        cycle("en.low", 1'b0, 1'b0, 16'h0000, 1'b1);
        chk("en.low_valid", int'(bus.Valid), 0);
        chk("en.low_y", int'(bus.Y), y_a);
        cycle("en.low2", 1'b0, 1'b1, 16'hFFFF, 1'b1);
        chk("en.low2_count", int'(bus.Count), 2);
        cycle("en.back", 1'b1, 1'b0, 16'h0000, 1'b0);
        chk("en.back_y", int'(bus.Y), y_a);
        cycle("en.go", 1'b1, 1'b0, 16'h0000, 1'b1);
        chk("en.next_y", int'(bus.Y), y_b);
        cycle("en.end", 1'b1, 1'b0, 16'h0000, 1'b1);

        // Asynchronous reset mid-SCAN
        cycle("ar.load", 1'b1, 1'b1, 16'hFFFF, 1'b1);
        cycle("ar.step", 1'b1, 1'b0, 16'h0000, 1'b1);
        #2 resetn = 1'b0;
        #1;
        chk("ar.y", int'(bus.Y), 0);
        chk("ar.valid", int'(bus.Valid), 0);
        chk("ar.busy", int'(bus.Busy), 0);
        chk("ar.count", int'(bus.Count), 0);
        q.delete();
        exp_done = 1'b0;
        exp_zero = 1'b0;
        @(negedge clk);
        chk("ar.no_done", int'(bus.Done), 0);
        resetn = 1'b1;
        cycle("ar.idle", 1'b1, 1'b0, 16'h0000, 1'b1);
        for (int i = 0; i < 5; i++) cycle("ar.reload", 1'b1, (i == 0), 16'h8421, 1'b1);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            cycle("rnd", ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) == 0),
                  rand_w(), 1'($urandom));
        end
        for (int i = 0; i < 20; i++) cycle("drain", 1'b1, 1'b0, 16'h0000, 1'b1);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/encoder_16to4_seq.md
Name: encoder_16to4_seq

Overview:
- Sequential 16-to-4 encoder. It is the inverse of the team's 4-to-16 decoder: it takes a 16-line word, where line i corresponds to code i, and emits the 4-bit code of every asserted line.
- Codes leave one per handshake, in priority order. Each served line is cleared from an internal pending register until that register is empty.
- Used to turn decoded request/interrupt lines back into binary codes for downstream logic.

Parameters:
- N, 16, number of input lines; must equal 2**M.
- M, 4, code width.

Ports:
- Clock  input  1  rising-edge clock.
- Resetn  input  1  asynchronous, active-low reset.
- En  input  1  global enable. When low, the block stalls.
- Load  input  1  capture W into the pending register; accepted only when Busy=0.
- W  input  N  decoded input lines; W[i] is line i.
- Y  output  M  code of the currently presented line.
- Valid  output  1  Y is valid.
- Ready  input  1  downstream accepts Y when Valid&Ready.
- Busy  output  1  pending register is non-empty, or the FSM is in SCAN.
- Count  output  M+1  number of lines still pending, including the one presented.
- Done  output  1  one-cycle pulse after the last code is accepted.
- Zero  output  1  one-cycle pulse when a Load is accepted with W==0.

Behaviour:
- Reset (Resetn=0, asynchronous): state=IDLE; pending=0; Y=0; Valid=0; Busy=0; Count=0; Done=0; Zero=0.
- FSM states: IDLE and SCAN.
- IDLE:
  - If En&Load and W!=0: pending<=W, Count<=popcount(W), go to SCAN.
  - If En&Load and W==0: stay in IDLE, pulse Zero for one cycle, pending unchanged.
  - Load with En=0 is ignored.
- SCAN:
  - Y = index of the lowest set bit of pending (line 0 has highest priority).
  - Valid=1.
  - Y and Valid are registered. Latency from the Load cycle to the first Valid is 1 clock.
- Handshake:
  - On a cycle where En&Valid&Ready: clear the served bit in pending and decrement Count.
  - The next code appears in the following cycle, so sustained throughput is 1 code per clock with Ready held high.
  - While Valid&!Ready: Y, Valid and pending are held stable.
  - Y must not change while Valid=1 and the code has not been accepted.
- Last code accepted: go to IDLE, Valid<=0, Count=0, Done pulses high for exactly the following cycle.
- Load while Busy=1 is ignored; W is not sampled.
- En=0 in SCAN: all state frozen, Valid forced low combinationally at the output, no handshake completes. Valid resumes with the same Y when En returns.
- Load and the final acceptance in the same cycle: the Load is ignored, because Busy=1 in that cycle. A new Load is accepted earliest on the Done cycle.
- Reset asserted mid-SCAN: all pending codes are discarded immediately and no Done pulse is produced.
- Width rules:
  - Count is M+1 bits so it can hold N=16.
  - popcount and the lowest-set-bit search are combinational over N bits. No truncation occurs.

Optional Feature:
- Macro: HIGH_PRIORITY_EN.
- Defined: priority is reversed. Y is the index of the highest set bit of pending (line N-1 first).
- Not defined: lowest index first, as described in Behaviour.
- All other timing, handshake and Count behaviour is identical in both builds.

Decomposition:
- Shared package encoder_pkg:
  - Constants N_LINES=16 and CODE_W=4.
  - State enum type enc_state_t {IDLE, SCAN}.
  - Pure function popcount over N_LINES bits.
- One sub-module is natural: prio_encode_16, a combinational priority encoder.
  - Input: N-bit vector. Outputs: M-bit index and an any-set flag.
  - Its priority direction is selected by HIGH_PRIORITY_EN.
  - Reused for both the Y selection and the served-bit clear mask.

Test Plan:
- Reset: hold Resetn=0 with random inputs -> Y=0, Valid=0, Busy=0, Count=0. Deassert; with no Load, outputs stay at 0.
- Load W=16'h8421, Ready=1 -> Y sequence 0,5,10,15 on consecutive cycles; Count 4,3,2,1; Done pulses 1 cycle after Y=15 is accepted. With HIGH_PRIORITY_EN the sequence is 15,10,5,0.
- Backpressure: Load W=16'h0006, Ready=0 for 3 cycles -> Y=1 held with Valid=1. Then Ready=1 -> Y=2, then Done.
- Load W=16'h0000 -> Zero pulses once, Busy stays 0. Load while Busy with W=16'hFFFF -> ignored, original sequence unaffected.
- En low: Load W=16'h0003, drop En after the first Valid -> Valid=0 and Y frozen. Raise En -> sequence resumes from the same Y.
- Resetn pulsed low mid-SCAN after Load W=16'hFFFF -> all outputs 0 asynchronously, no Done. Next Load works normally.
